// File: rtl/i2s_resample_sched.sv
// i2s_resample_sched
//   Bit-clock scheduler for an I2S output that reads from an 8-entry sample
//   FIFO filled in another clock domain. It generates the output word
//   select, the per-bit read address for the serialising datapath and a
//   bit-clock enable. Whenever a FIFO entry has been used for
//   FRAMES_PER_SAMPLE frames it advances the read index. The step size
//   depends on FIFO occupancy, so the output rate slips to follow the
//   writer: +2 (drop) when the FIFO is nearly full, +0 (repeat) when it is
//   nearly empty, and +1 otherwise.
//
// Ports
//   I2S_BCK      in   single clock, all logic on its rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   run request (synchronous)
//   wr_idx_gray  in   [2:0] Gray-coded FIFO write index (foreign domain)
//   rd_idx       out  [2:0] FIFO entry currently read
//   I2S_WS_OUT   out  word select: 0 = left half, 1 = right half
//   chan_sel     out  channel of the bit being read (0 = L, 1 = R)
//   bit_sel      out  [3:0] bit index being read, MSB first
//   shift_en     out  valid qualifier for chan_sel/bit_sel
//   mute         out  datapath sends zeros instead of FIFO data
//   bck_en       out  bit-clock gate enable
//   drop_pulse   out  1-cycle pulse: one entry skipped
//   repeat_pulse out  1-cycle pulse: entry reused
//   state        out  [1:0] FSM state: 0 IDLE, 1 FILL, 2 RUN
//
// Handshake: shift_en is a plain valid for {chan_sel, bit_sel}. The
// datapath has no ready, and it must consume the bit in every cycle in
// which shift_en is 1. While shift_en is 0, chan_sel and bit_sel are 0.
//
// Build option: define I2S_SCHED_CLK_GATING_EN to gate bck_en down to the
// shifting cycles plus one trailing cycle. When the macro is not defined,
// bck_en is high in FILL and RUN.
//
// Every output is registered. Each one shows the frame position
// (fcnt/state) of the previous cycle.

module i2s_resample_sched #(
  parameter int FRAME_BCK         = 83,
  parameter int RIGHT_START       = 42,
  parameter int SAMPLE_BITS       = 16,
  parameter int FRAMES_PER_SAMPLE = 2,
  parameter int HI_TH             = 6,
  parameter int LO_TH             = 1,
  parameter int START_TH          = 4
) (
  input  logic       I2S_BCK,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] wr_idx_gray,
  output logic [2:0] rd_idx,
  output logic       I2S_WS_OUT,
  output logic       chan_sel,
  output logic [3:0] bit_sel,
  output logic       shift_en,
  output logic       mute,
  output logic       bck_en,
  output logic       drop_pulse,
  output logic       repeat_pulse,
  output logic [1:0] state
);

  localparam int FW = $clog2(FRAME_BCK);
  localparam int NW = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;

  localparam logic [FW-1:0] F_LAST = FW'(FRAME_BCK - 1);
  localparam logic [FW-1:0] F_RS   = FW'(RIGHT_START);
  localparam logic [FW-1:0] F_SB   = FW'(SAMPLE_BITS);
  localparam logic [FW-1:0] F_RE   = FW'(RIGHT_START + SAMPLE_BITS);
  localparam logic [FW-1:0] F_SBM1 = FW'(SAMPLE_BITS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(FRAMES_PER_SAMPLE - 1);

  localparam logic [2:0] HI    = 3'(HI_TH);
  localparam logic [2:0] LO    = 3'(LO_TH);
  localparam logic [2:0] START = 3'(START_TH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        cur_state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [NW-1:0] frm_cnt, frm_nxt;
  logic [2:0]    rd_nxt;
  logic          stop_pend, stop_nxt;
  logic          drop_nxt, rep_nxt;

  logic [2:0]    sync1, sync2;
  logic [2:0]    wr_bin, occ;
  logic          wrap;

  // Write-index crossing. A Gray code changes one bit per step, so the
  // two-flop synchronizer always yields either the old or the new index.
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      sync1 <= 3'd0;
      sync2 <= 3'd0;
    end else begin
      sync1 <= wr_idx_gray;
      sync2 <= sync1;
    end
  end

  assign wr_bin[2] = sync2[2];
  assign wr_bin[1] = sync2[2] ^ sync2[1];
  assign wr_bin[0] = sync2[2] ^ sync2[1] ^ sync2[0];
  assign occ       = wr_bin - rd_idx;   // mod-8 wrap is intended

  assign wrap  = (fcnt == F_LAST);
  assign state = cur_state;

  // FSM state register
  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= state_nxt;
  end

  // Next state, frame counting and read-index slip decisions
  always_comb begin
    state_nxt = cur_state;
    fcnt_nxt  = fcnt;
    frm_nxt   = frm_cnt;
    rd_nxt    = rd_idx;
    stop_nxt  = stop_pend;
    drop_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        fcnt_nxt = '0;
        frm_nxt  = '0;
        stop_nxt = 1'b0;
        if (enable) state_nxt = S_FILL;
      end
      S_FILL, S_RUN: begin
        // A stop request is remembered so the current frame always finishes.
        stop_nxt = stop_pend | ~enable;
        fcnt_nxt = wrap ? '0 : fcnt + 1'b1;
        if (wrap) begin
          if (stop_nxt) begin
            state_nxt = S_IDLE;
            frm_nxt   = '0;
            stop_nxt  = 1'b0;
          end else if (cur_state == S_FILL) begin
            frm_nxt = '0;
            if (occ >= START) state_nxt = S_RUN;
          end else if (frm_cnt == N_LAST) begin
            frm_nxt = '0;
            // An empty FIFO overrides slip handling: refill and hold rd_idx.
            if (occ == 3'd0) begin
              state_nxt = S_FILL;
            end else if (occ >= HI) begin
              rd_nxt   = rd_idx + 3'd2;
              drop_nxt = 1'b1;
            end else if (occ <= LO) begin
              rep_nxt = 1'b1;
            end else begin
              rd_nxt = rd_idx + 3'd1;
            end
          end else begin
            frm_nxt = frm_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current frame position. It is registered below,
  // which gives every output the same one-cycle latency.
  logic          active, in_l, in_r;
  logic          ws_d, shift_d, chan_d, mute_d, bck_d;
  logic [FW-1:0] offs;
  logic [3:0]    bit_d;

  always_comb begin
    active  = (cur_state != S_IDLE);
    in_l    = (fcnt < F_SB);
    in_r    = (fcnt >= F_RS) && (fcnt < F_RE);
    shift_d = active && (in_l || in_r);
    chan_d  = shift_d && in_r;
    offs    = in_r ? (fcnt - F_RS) : fcnt;
    bit_d   = shift_d ? 4'(F_SBM1 - offs) : 4'd0;
    ws_d    = active && (fcnt >= F_RS);
    mute_d  = (cur_state != S_RUN);
`ifdef I2S_SCHED_CLK_GATING_EN
    // Keep the clock running for one cycle after the last shifted bit.
    bck_d   = shift_d | shift_en;
`else
    bck_d   = active;
`endif
  end

  always_ff @(posedge I2S_BCK or posedge reset) begin
    if (reset) begin
      fcnt         <= '0;
      frm_cnt      <= '0;
      rd_idx       <= 3'd0;
      stop_pend    <= 1'b0;
      I2S_WS_OUT   <= 1'b0;
      shift_en     <= 1'b0;
      chan_sel     <= 1'b0;
      bit_sel      <= 4'd0;
      mute         <= 1'b1;
      bck_en       <= 1'b0;
      drop_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      fcnt         <= fcnt_nxt;
      frm_cnt      <= frm_nxt;
      rd_idx       <= rd_nxt;
      stop_pend    <= stop_nxt;
      I2S_WS_OUT   <= ws_d;
      shift_en     <= shift_d;
      chan_sel     <= chan_d;
      bit_sel      <= bit_d;
      mute         <= mute_d;
      bck_en       <= bck_d;
      drop_pulse   <= drop_nxt;
      repeat_pulse <= rep_nxt;
    end
  end

endmodule

// File: doc/i2s_resample_sched.md
I2S_RESAMPLE_SCHED -- requirements
Module: i2s_resample_sched

Interface
REQ-001 SHALL have parameter FRAME_BCK, default 83: output BCK cycles per output frame (left and right halves).
REQ-002 SHALL have parameter RIGHT_START, default 42: frame-counter value where the right half starts.
REQ-003 SHALL have parameter SAMPLE_BITS, default 16: bits shifted per channel.
REQ-004 SHALL have parameter FRAMES_PER_SAMPLE, default 2: output frames per consumed FIFO entry.
REQ-005 SHALL have parameters HI_TH (6), LO_TH (1) and START_TH (4): occupancy thresholds, in entries.
REQ-006 SHALL have port I2S_BCK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit: synchronous run request.
REQ-009 SHALL have port wr_idx_gray, input, 3 bits: Gray-coded FIFO write index from the capture domain.
REQ-010 SHALL have port rd_idx, output, 3 bits: FIFO entry being read.
REQ-011 SHALL have port I2S_WS_OUT, output, 1 bit: output word select.
REQ-012 SHALL have ports chan_sel (1 bit; 0=L, 1=R), bit_sel (4 bits) and shift_en (1 bit), all outputs: bit-read address and valid for the datapath.
REQ-013 SHALL have port mute, output, 1 bit: datapath drives 0 instead of FIFO data.
REQ-014 SHALL have port bck_en, output, 1 bit: output bit-clock gate enable.
REQ-015 SHALL have ports drop_pulse and repeat_pulse, outputs, 1 bit each: 1-cycle slip indications.
REQ-016 SHALL have port state, output, 2 bits: 0 IDLE, 1 FILL, 2 RUN.

Function
REQ-017 SHALL synchronize wr_idx_gray through 2 flops, convert Gray to binary, and compute occ = (wr_bin - rd_idx) mod 8.
REQ-018 SHALL run frame counter fcnt 0..FRAME_BCK-1 in FILL and RUN, wrapping to 0; fcnt held at 0 in IDLE.
REQ-019 SHALL register all outputs, each reflecting the fcnt value of the previous cycle (1-cycle latency).
REQ-020 SHALL drive I2S_WS_OUT=0 for fcnt<RIGHT_START and 1 otherwise; held 0 in IDLE.
REQ-021 SHALL assert shift_en for SAMPLE_BITS cycles starting at fcnt=0 (chan_sel=0) and at fcnt=RIGHT_START (chan_sel=1), with bit_sel counting SAMPLE_BITS-1 down to 0 (MSB first).
REQ-022 SHALL drive bit_sel=0 and chan_sel=0 while shift_en=0.
REQ-023 SHALL count frames in RUN and, at the wrap of every FRAMES_PER_SAMPLE-th frame, update rd_idx: +2 with drop_pulse if occ>=HI_TH; +0 with repeat_pulse if occ<=LO_TH; otherwise +1.
REQ-024 SHALL apply all rd_idx arithmetic modulo 8 (3-bit wrap, 7+2=1).
REQ-025 SHALL leave rd_idx unchanged except at the frame boundaries in REQ-023 and REQ-028.
REQ-026 SHALL transition IDLE->FILL when enable=1.
REQ-027 SHALL transition FILL->RUN at a frame wrap when occ>=START_TH.
REQ-028 SHALL transition RUN->FILL on a rd_idx update where occ=0; this transition has priority over REQ-023, and rd_idx is held.
REQ-029 SHALL transition to IDLE from FILL or RUN when enable=0, taking effect at the next frame wrap; the current frame completes.
REQ-030 SHALL assert mute in IDLE and FILL and deassert it in RUN.
REQ-031 SHALL not assert drop_pulse and repeat_pulse in the same cycle.

Reset
REQ-032 SHALL set, on reset, state=IDLE, fcnt=0, frame count=0, rd_idx=0, synchronizer flops=0, I2S_WS_OUT=0, shift_en=0, bit_sel=0, chan_sel=0, mute=1, bck_en=0, drop_pulse=0, repeat_pulse=0.
REQ-033 SHALL abort any frame on reset assertion mid-operation, with no partial-frame completion after release.

Configuration
REQ-034 SHALL gate bck_en when macro I2S_SCHED_CLK_GATING_EN is defined: bck_en=1 only in cycles with shift_en=1, plus one trailing cycle.
REQ-035 SHALL drive bck_en=1 in FILL and RUN, and 0 in IDLE, when I2S_SCHED_CLK_GATING_EN is undefined.

Verification
REQ-036 SHALL verify start-up: reset, enable=1, wr_idx steps to 4 -> state FILL->RUN at next wrap, mute falls, shift_en high 16 cycles at fcnt 0 and 42 with bit_sel 15..0.
REQ-037 SHALL verify nominal rate: occ held at 3 -> rd_idx +1 every 166 cycles, no pulses.
REQ-038 SHALL verify drop: occ=6 at boundary -> rd_idx +2, drop_pulse for 1 cycle; rd_idx=7 -> 1.
REQ-039 SHALL verify repeat and underflow: occ=1 -> rd_idx held, repeat_pulse; occ=0 -> state FILL, mute=1.
REQ-040 SHALL verify stop and reset: enable=0 at fcnt=20 -> IDLE at wrap (cycle 83); reset at fcnt=50 -> all REQ-032 values next cycle.
REQ-041 SHALL verify gating: with I2S_SCHED_CLK_GATING_EN, bck_en high 17 cycles per half-frame; without it, bck_en constant 1 in RUN.
